// File: rtl/reg_writeback.sv
// Writeback stage: X->WB pipeline register, writeback value selection, reg_file
// write port, decode forwarding selects and retired-instruction counter.
module reg_writeback #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             x_valid,
  input  logic [31:0]      x_inst,
  input  logic [31:0]      x_pc,
  input  logic [31:0]      x_alu,
  input  logic [31:0]      dmem_dout,
  input  logic [31:0]      d_inst,
  output logic             we,
  output logic [4:0]       wa,
  output logic [31:0]      wd,
  output logic [31:0]      wb_val,
  output logic             wb2d_a,
  output logic             wb2d_b,
  output logic             wb_valid,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic             r_valid;
  logic [31:0]      r_inst;
  logic [31:0]      r_pc;
  logic [31:0]      r_alu;
  logic [CNT_W-1:0] r_instret;

  logic [6:0]  w_opc;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic        w_writes_rd;
  logic        w_we;
  logic [4:0]  w_wa;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wd;
  logic        w_unused;

  // WB pipeline register; stall outranks flush, instret counts instructions leaving WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_inst    <= NOP_INST;
      r_pc      <= 32'h0;
      r_alu     <= 32'h0;
      r_instret <= '0;
    end else if (!stall) begin
      if (r_valid) r_instret <= r_instret + CNT_W'(1);
      if (flush) begin
        r_valid <= 1'b0;
        r_inst  <= NOP_INST;
      end else begin
        r_valid <= x_valid;
        r_inst  <= x_inst;
        r_pc    <= x_pc;
        r_alu   <= x_alu;
      end
    end
  end

  assign w_opc = r_inst[6:0];
  assign w_rd  = r_inst[11:7];
  assign w_f3  = r_inst[14:12];

  always_comb begin
    w_writes_rd = 1'b0;
    case (w_opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: w_writes_rd = 1'b1;
      default:                      w_writes_rd = 1'b0;
    endcase
  end

  // Load alignment: byte lane from alu[1:0], halfword lane from alu[1]
  always_comb begin
    w_byte = 8'h00;
    case (r_alu[1:0])
      2'd0:    w_byte = dmem_dout[7:0];
      2'd1:    w_byte = dmem_dout[15:8];
      2'd2:    w_byte = dmem_dout[23:16];
      default: w_byte = dmem_dout[31:24];
    endcase
    w_half = r_alu[1] ? dmem_dout[31:16] : dmem_dout[15:0];
    w_load = dmem_dout;
    case (w_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = dmem_dout;
    endcase
  end

  always_comb begin
    w_wd = r_alu;
    if (w_opc == OPC_JAL || w_opc == OPC_JALR) w_wd = r_pc + 32'd4;
    else if (w_opc == OPC_LOAD)                w_wd = w_load;
  end

  assign w_we = r_valid & w_writes_rd & (w_rd != 5'd0);
  assign w_wa = r_valid ? w_rd : 5'd0;

  assign we       = w_we;
  assign wa       = w_wa;
  assign wd       = w_wd;
  assign wb_val   = w_wd;
  assign wb2d_a   = w_we & (w_wa == d_inst[19:15]);
  assign wb2d_b   = w_we & (w_wa == d_inst[24:20]);
  assign wb_valid = r_valid;
  assign instret  = r_instret;

  assign w_unused = ^{d_inst[31:25], d_inst[14:0], r_inst[31:15]};

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback against a behavioural WB-stage model.
module tb_reg_writeback;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
                         LUI = 7'b0110111, AUI = 7'b0010111, JAL = 7'b1101111,
                         JALR = 7'b1100111, ST = 7'b0100011, BR = 7'b1100011,
                         SYS = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst, stall, flush, x_valid;
  logic [31:0] x_inst, x_pc, x_alu, dmem_dout, d_inst;
  logic        we, wb2d_a, wb2d_b, wb_valid;
  logic [4:0]  wa;
  logic [31:0] wd, wb_val, instret;

  int n_chk = 0;
  int n_err = 0;

  // behavioural model of WB contents
  logic        m_valid;
  logic [31:0] m_inst, m_pc, m_alu, m_instret;

  reg_writeback #(.NOP_INST(NOP), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .x_valid(x_valid),
    .x_inst(x_inst), .x_pc(x_pc), .x_alu(x_alu), .dmem_dout(dmem_dout),
    .d_inst(d_inst), .we(we), .wa(wa), .wd(wd), .wb_val(wb_val),
    .wb2d_a(wb2d_a), .wb2d_b(wb2d_b), .wb_valid(wb_valid), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [2:0] f3, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, rd, op};
  endfunction

  function automatic bit ref_writes(input logic [6:0] op);
    return op inside {OP, OPI, LD, LUI, AUI, JAL, JALR};
  endfunction

  function automatic logic [31:0] ref_wd(input logic [31:0] inst, input logic [31:0] pc,
                                         input logic [31:0] alu, input logic [31:0] dout);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(dout >> (8 * int'(alu[1:0])));
    h = 16'(dout >> (16 * int'(alu[1])));
    if (inst[6:0] == JAL || inst[6:0] == JALR) return pc + 32'd4;
    if (inst[6:0] != LD) return alu;
    case (inst[14:12])
      3'd0:    return 32'(int'($signed(b)));
      3'd4:    return 32'(b);
      3'd1:    return 32'(int'($signed(h)));
      3'd5:    return 32'(h);
      default: return dout;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_inst = NOP; m_pc = 32'h0; m_alu = 32'h0; m_instret = 32'h0;
  endtask

  task automatic check_model();
    logic [4:0] rd;
    logic       ewe;
    logic [4:0] ewa;
    logic [31:0] ewd;
    rd  = m_inst[11:7];
    ewe = m_valid && ref_writes(m_inst[6:0]) && rd != 5'd0;
    ewa = m_valid ? rd : 5'd0;
    ewd = ref_wd(m_inst, m_pc, m_alu, dmem_dout);
    chk("we", we, ewe);
    chk("wa", wa, ewa);
    chk("wd", wd, ewd);
    chk("wb_val", wb_val, ewd);
    chk("wb2d_a", wb2d_a, ewe && ewa == d_inst[19:15]);
    chk("wb2d_b", wb2d_b, ewe && ewa == d_inst[24:20]);
    chk("wb_valid", wb_valid, m_valid);
    chk("instret", instret, m_instret);
  endtask

  // called at a negedge: drive inputs, let them settle, compare against model
  task automatic apply(input logic xv, input logic [31:0] xi, input logic [31:0] xp,
                       input logic [31:0] xa, input logic st, input logic fl,
                       input logic [31:0] di, input logic [31:0] dd);
    x_valid = xv; x_inst = xi; x_pc = xp; x_alu = xa;
    stall = st; flush = fl; d_inst = di; dmem_dout = dd;
    #1 check_model();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (!stall) begin
      if (m_valid) m_instret = m_instret + 32'd1;
      if (flush) begin
        m_valid = 1'b0; m_inst = NOP;
      end else begin
        m_valid = x_valid; m_inst = x_inst; m_pc = x_pc; m_alu = x_alu;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] dout,
                         input logic [31:0] di, input logic [31:0] exp_wd,
                         input logic exp_we);
    logic [31:0] ir0;
    apply(1'b1, inst, pc, alu, 1'b0, 1'b0, di, dout);
    clk_edge();
    apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, di, dout);
    chk({tag, "_we"}, we, exp_we);
    chk({tag, "_wd"}, wd, exp_wd);
    ir0 = m_instret;
    clk_edge();
    chk({tag, "_instret"}, instret, ir0 + 32'd1);
  endtask

  initial begin
    logic [31:0] base;
    logic [6:0]  ops [10];
    ops = '{OP, OPI, LD, LUI, AUI, JAL, JALR, ST, BR, SYS};
    rst = 1'b1; stall = 1'b0; flush = 1'b0; x_valid = 1'b0;
    x_inst = 32'h0; x_pc = 32'h0; x_alu = 32'h0; dmem_dout = 32'h0; d_inst = 32'h0;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_we", we, 1'b0);
    chk("rst_wb2d_a", wb2d_a, 1'b0);
    chk("rst_wb2d_b", wb2d_b, 1'b0);
    chk("rst_instret", instret, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    clk_edge();

    // ADD x4 with forwarding to rs1
    apply(1'b1, mk(OP, 5'd4, 3'd0, 5'd1, 5'd2), 32'h40, 32'd1000, 1'b0, 1'b0, 32'h0, 32'h0);
    clk_edge();
    apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, mk(OP, 5'd9, 3'd0, 5'd4, 5'd5), 32'h0);
    chk("add_we", we, 1'b1);
    chk("add_wa", wa, 5'd4);
    chk("add_wd", wd, 32'd1000);
    chk("add_wb_val", wb_val, 32'd1000);
    chk("add_fwd_a", wb2d_a, 1'b1);
    chk("add_fwd_b", wb2d_b, 1'b0);
    clk_edge();
    apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("add_after_we", we, 1'b0);
    chk("add_after_instret", instret, 32'd1);
    clk_edge();

    // async reset while an ADD sits in WB
    apply(1'b1, mk(OP, 5'd4, 3'd0, 5'd1, 5'd2), 32'h40, 32'd1000, 1'b0, 1'b0, 32'h0, 32'h0);
    clk_edge();
    apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, mk(OP, 5'd0, 3'd0, 5'd4, 5'd4), 32'h0);
    chk("prerst_we", we, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_we", we, 1'b0);
    chk("midrst_wb2d_a", wb2d_a, 1'b0);
    chk("midrst_wb2d_b", wb2d_b, 1'b0);
    chk("midrst_instret", instret, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    clk_edge();

    // loads, JAL, store
    run_one("lb",  mk(LD, 5'd6, 3'd0, 5'd1, 5'd0), 32'h0, 32'h2002, 32'h1280_3456, 32'h0, 32'hFFFF_FF80, 1'b1);
    run_one("lbu", mk(LD, 5'd6, 3'd4, 5'd1, 5'd0), 32'h0, 32'h2002, 32'h1280_3456, 32'h0, 32'h0000_0080, 1'b1);
    run_one("lh",  mk(LD, 5'd6, 3'd1, 5'd1, 5'd0), 32'h0, 32'h2002, 32'h1280_3456, 32'h0, 32'h0000_1280, 1'b1);
    run_one("lhu", mk(LD, 5'd6, 3'd5, 5'd1, 5'd0), 32'h0, 32'h2001, 32'h8765_F234, 32'h0, 32'h0000_F234, 1'b1);
    run_one("lw",  mk(LD, 5'd6, 3'd2, 5'd1, 5'd0), 32'h0, 32'h2003, 32'h1280_3456, 32'h0, 32'h1280_3456, 1'b1);
    run_one("jal", mk(JAL, 5'd1, 3'd0, 5'd0, 5'd0), 32'h100, 32'h0, 32'h0, 32'h0, 32'h104, 1'b1);
    run_one("jalr_wrap", mk(JALR, 5'd1, 3'd0, 5'd2, 5'd0), 32'hFFFF_FFFC, 32'h55, 32'h0, 32'h0, 32'h0, 1'b1);
    apply(1'b1, mk(JAL, 5'd0, 3'd0, 5'd0, 5'd0), 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    clk_edge();
    apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, mk(OP, 5'd3, 3'd0, 5'd0, 5'd0), 32'h0);
    chk("jal_x0_we", we, 1'b0);
    chk("jal_x0_fwd_a", wb2d_a, 1'b0);
    clk_edge();
    run_one("sw", {7'd0, 5'd3, 5'd2, 3'd2, 5'd8, ST}, 32'h0, 32'h123, 32'h0, 32'h0, 32'h123, 1'b0);

    // flush kills ADDI x5
    apply(1'b1, mk(OPI, 5'd5, 3'd0, 5'd0, 5'd0), 32'h0, 32'd666, 1'b0, 1'b1, 32'h0, 32'h0);
    clk_edge();
    apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("flush_valid", wb_valid, 1'b0);
    chk("flush_we", we, 1'b0);
    clk_edge();

    // ADDI x5 held by a 3-cycle stall (one stalled cycle also flushes)
    base = m_instret;
    apply(1'b1, mk(OPI, 5'd5, 3'd0, 5'd0, 5'd0), 32'h0, 32'd666, 1'b0, 1'b0, 32'h0, 32'h0);
    clk_edge();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, mk(OP, 5'd9, 3'd0, 5'd0, 5'd0), 32'h0, 32'd7, 1'b1, i == 1, 32'h0, 32'h0);
      chk("stall_we", we, 1'b1);
      chk("stall_wd", wd, 32'd666);
      chk("stall_instret", instret, base);
      clk_edge();
    end
    apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("stall_end_wd", wd, 32'd666);
    clk_edge();
    chk("stall_instret_once", instret, base + 32'd1);

    // dual forward to rs1 and rs2
    apply(1'b1, mk(OP, 5'd7, 3'd0, 5'd1, 5'd2), 32'h0, 32'h77, 1'b0, 1'b0, 32'h0, 32'h0);
    clk_edge();
    apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, mk(OP, 5'd1, 3'd0, 5'd7, 5'd7), 32'h0);
    chk("dual_a", wb2d_a, 1'b1);
    chk("dual_b", wb2d_b, 1'b1);
    clk_edge();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ri, rp;
      ri = $urandom;
      ri[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      ri[11:7] = 5'($urandom_range(0, 7));
      rp = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      apply($urandom_range(0, 3) != 0, ri, rp, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            mk(7'($urandom), 5'($urandom), 3'($urandom),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
            $urandom);
      clk_edge();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side counterpart of the decode-stage register read path.
- Holds the X->WB pipeline register and forms the writeback value (ALU result, load data, or link address).
- Drives the reg_file write port (we/wa/wd).
- Generates the wb2d_a/wb2d_b forwarding selects and wb_val consumed by read_from_reg, and keeps a retired-instruction counter.

Parameters:
- NOP_INST, 32'h0000_0013: instruction loaded into the WB stage as a bubble (addi x0,x0,0).
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freezes the WB pipeline register and instret.
- flush  in  1  loads a bubble into WB on the next edge instead of X-stage contents.
- x_valid  in  1  X-stage instruction valid.
- x_inst  in  32  X-stage instruction.
- x_pc  in  32  X-stage PC.
- x_alu  in  32  X-stage ALU result; this is also the data address for loads.
- dmem_dout  in  32  data memory read word; valid during the WB cycle of a load.
- d_inst  in  32  instruction currently in decode, used for the forwarding compare.
- we  out  1  reg_file write enable.
- wa  out  5  reg_file write address.
- wd  out  32  reg_file write data.
- wb_val  out  32  forwarding value; always equal to wd.
- wb2d_a  out  1  forwarding select for rs1.
- wb2d_b  out  1  forwarding select for rs2.
- wb_valid  out  1  WB stage holds a valid instruction.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset, asserted asynchronously:
  - wb_valid=0, WB inst=NOP_INST, WB pc=0, WB alu=0, instret=0.
  - Consequently we, wb2d_a and wb2d_b fall to 0 combinationally without waiting for a clock edge.
  - Reset asserted mid-operation discards the WB instruction; no write occurs.
- Pipeline register, updated on posedge clk:
  - stall=1: hold all WB state. stall takes priority over flush.
  - else flush=1: wb_valid<=0, inst<=NOP_INST.
  - else: wb_valid<=x_valid and inst/pc/alu <= x_inst/x_pc/x_alu.
- Latency: an instruction presented on the X inputs drives the write port for exactly one cycle after the next unstalled edge; during a stall it is held for longer.
- Opcode classes that write rd (rd = inst[11:7]):
  - OP 0110011, OP-IMM 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - All other opcodes never write: STORE, BRANCH, SYSTEM, and any unknown opcode.
- Enable and address:
  - we = wb_valid & writes_rd & (rd != 0). Writes to x0 are suppressed.
  - wa = rd whenever wb_valid; otherwise 0.
  - we stays asserted during a stall. Rewriting the same value is idempotent.
- Write data selection:
  - JAL/JALR: pc+4, 32-bit wrap (pc=32'hFFFF_FFFC gives 0).
  - LOAD: extracted load data as below.
  - Everything else: alu.
- Load extraction, with off = alu[1:0] and funct3 = inst[14:12]:
  - LB 000: byte off, sign-extended.
  - LBU 100: byte off, zero-extended.
  - LH 001: halfword selected by off[1], sign-extended; off[0] is ignored.
  - LHU 101: halfword selected by off[1], zero-extended; off[0] is ignored.
  - LW 010: full word; off is ignored.
  - Other funct3: full word.
- Forwarding:
  - wb2d_a = we & (wa == d_inst[19:15]); wb2d_b = we & (wa == d_inst[24:20]).
  - Both may assert in the same cycle. Neither asserts for rd=0.
  - The compare is applied regardless of d_inst format.
- instret increments by 1 on an edge where wb_valid=1, stall=0 and rst=0. This includes non-writing instructions (stores, branches). The counter wraps at 2^CNT_W.
- Outputs are combinational from WB state and d_inst/dmem_dout; there is no additional cycle.

Test Plan:
- Reset, then no stimulus -> we=0, wb2d_a=0, wb2d_b=0, instret=0. Assert rst mid-cycle while an ADD is in WB -> we drops immediately.
- ADD x4 with x_alu=1000, one edge, d_inst rs1=4 and rs2=5 -> we=1, wa=4, wd=wb_val=1000, wb2d_a=1, wb2d_b=0. Next cycle with x_valid=0 -> we=0, instret=1.
- LB at alu=...02 with dmem_dout=32'h1280_3456 -> wd=32'hFFFF_FF80. LBU at the same address -> 32'h80. LH at alu=...02 -> 32'h0000_1280. LW -> 32'h1280_3456.
- JAL x1 with pc=32'h100 -> wd=32'h104, we=1. JAL x0 -> we=0 and wb2d_a=0 even though d_inst rs1=0. SW -> we=0, but instret still increments.
- ADDI x5 =666 with flush=1 on its edge -> wb_valid=0, we=0. Repeat with stall=1 held 3 cycles -> we held at 1 with wd=666 throughout, instret increments only once, on the first unstalled edge after the instruction enters WB.
- d_inst with rs1=rs2=7 and an OP writing x7 -> wb2d_a=1 and wb2d_b=1 simultaneously.
